ic_mem_arbiter: RTL and testbench
=================================

// Module: ic_mem_arbiter
// PURPOSE
//  Shares one memory target port (RAM or ROM) between the CPU imem and dmem routed ports.
//  Sits between the address-decode and response-routing stage and a single-ported memory.
//  Arbitrates requests using req/gnt, tracks ownership of in-flight transactions in order,
//  and returns each response (recv/ack) to the requester that issued it.
// PARAMETERS
//  OUTSTANDING  2  max granted-but-unacknowledged transactions (ownership FIFO depth, 1..4)
// PORTS
//  g_clk        in   1   clock, all state on rising edge
//  g_resetn     in   1   asynchronous active-low reset
//  imem_req,imem_wen / imem_strb / imem_wdata,imem_addr   in 1,1/4/32,32  imem request fields
//  imem_gnt,imem_recv,imem_error / imem_rdata             out 1,1,1/32     imem request/response
//  imem_ack     in   1   imem accepts response
//  dmem_*       same set, widths and directions as imem_*    dmem requester
//  mem_req,mem_wen / mem_strb / mem_wdata,mem_addr        out 1,1/4/32,32  shared target request
//  mem_gnt,mem_recv,mem_error / mem_rdata                 in 1,1,1/32      target grant/response
//  mem_ack      out  1   forwarded owner ack
//  arb_pending  out  3   current ownership FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, lock clear, rr_last=imem (dmem wins the first tie). All outputs are 0
//   while g_resetn=0. After deassertion, outputs are combinational functions of the state.
//  Arbitration (combinational):
//   - sel = lock_valid ? lock_sel : winner of {imem_req, dmem_req}.
//   - Tie goes to the requester not equal to rr_last.
//   - mem_req = (imem_req|dmem_req) & !fifo_full. Request fields are muxed by sel.
//   - <x>_gnt = mem_gnt & mem_req & (sel==x). Zero-latency grant path.
//  Lock: if mem_req=1 and mem_gnt=0, set lock_valid and lock_sel=sel.
//   - Lock clears on the grant cycle. Selection never switches while a request is stalled.
//   - If the locked requester drops req (protocol violation), the lock clears next cycle.
//  Grant cycle (mem_req & mem_gnt):
//   - Push sel into the ownership FIFO and set rr_last=sel.
//  Response:
//   - owner = FIFO head.
//   - <owner>_recv = mem_recv & !fifo_empty. rdata/error are routed to the owner only.
//   - Non-owner recv/error/rdata are 0.
//   - mem_ack = owner_ack & !fifo_empty. Pop on mem_recv & mem_ack.
//  FIFO full: mem_req is forced 0. A pop in the same cycle does not unblock a push;
//   a request may be granted the next cycle earliest.
//  Simultaneous push+pop when not full: occupancy unchanged, order preserved.
//  mem_recv with FIFO empty: ignored, no recv to either side, mem_ack=0.
//  arb_pending is 0..OUTSTANDING. Wrap-around: rd/wr pointers mod OUTSTANDING.
//  Reset mid-transaction: FIFO is flushed. Late target responses are dropped (FIFO empty rule).
// CONFIGURATION
//  IC_ARB_DMEM_PRIO_EN defined:
//   - Fixed priority: dmem always wins a tie and rr_last is unused.
//   - The lock rule still applies, so a stalled imem request is not preempted.
//  IC_ARB_DMEM_PRIO_EN undefined: round-robin as above.
// TESTING
//  1. Reset, then imem_req addr=0x2000_0010 with mem_gnt=1 -> imem_gnt same cycle, arb_pending=1;
//     mem_recv with rdata=0xDEAD_BEEF, imem_ack=1 -> imem_rdata=0xDEAD_BEEF, dmem_recv=0, pending=0.
//  2. imem_req & dmem_req held, mem_gnt=1 for 4 cycles, ack every cycle ->
//     grant order dmem, imem, dmem, imem (round-robin).
//  3. dmem_req, mem_gnt=0 for 3 cycles, then imem_req raised -> mem_addr stays on dmem;
//     dmem granted when mem_gnt=1.
//  4. OUTSTANDING=2, grant imem then dmem, no recv -> mem_req=0 with a third req pending;
//     recv+ack pops imem first (imem_recv=1), req re-asserts next cycle.
//  5. mem_recv=1 with pending=0 -> no recv/error on either side, mem_ack=0, no state change.
//  6. IC_ARB_DMEM_PRIO_EN: both req for 3 grants -> dmem, dmem, dmem.
//     Assert g_resetn=0 with pending=2 -> pending=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/ic_mem_arbiter_if.sv
// rtl/ic_mem_arbiter_if.sv - memory port bundle (request, grant, response) shared by requesters and target
interface ic_mem_if;
  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        gnt;
  logic        recv;
  logic        error;
  logic [31:0] rdata;
  logic        ack;

  // Side that issues requests and accepts responses
  modport master (
    output req, wen, strb, wdata, addr, ack,
    input  gnt, recv, error, rdata
  );

  // Side that grants requests and returns responses
  modport slave (
    input  req, wen, strb, wdata, addr, ack,
    output gnt, recv, error, rdata
  );
endinterface

// File: rtl/ic_mem_arbiter.sv
// rtl/ic_mem_arbiter.sv - imem/dmem arbiter onto one memory port with in-order ownership FIFO (option: IC_ARB_DMEM_PRIO_EN)
module ic_mem_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  ic_mem_if.slave    imem,
  ic_mem_if.slave    dmem,
  ic_mem_if.master   mem,
  output logic [2:0] arb_pending
);

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;
  localparam int   PW       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
  localparam logic [2:0]    CNT_FULL = 3'(OUTSTANDING);

  logic          lock_valid_q, lock_valid_d;
  logic          lock_sel_q, lock_sel_d;
  logic          own_q [OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
`ifndef IC_ARB_DMEM_PRIO_EN
  logic          rr_last_q, rr_last_d;
`endif

  logic winner, sel, owner, owner_ack, locked_req;
  logic fifo_full, fifo_empty, req_any, push, ack_int, pop;

  // Request selection, FIFO status and handshake qualifiers
  always_comb begin
    winner = SEL_IMEM;
    if (imem.req && dmem.req) begin
`ifdef IC_ARB_DMEM_PRIO_EN
      winner = SEL_DMEM;
`else
      winner = (rr_last_q == SEL_IMEM) ? SEL_DMEM : SEL_IMEM;
`endif
    end else if (dmem.req) begin
      winner = SEL_DMEM;
    end
    sel        = lock_valid_q ? lock_sel_q : winner;
    locked_req = lock_sel_q ? dmem.req : imem.req;
    fifo_full  = (count_q == CNT_FULL);
    fifo_empty = (count_q == 3'd0);
    req_any    = g_resetn & (imem.req | dmem.req) & ~fifo_full;
    push       = req_any & mem.gnt;
    owner      = own_q[rd_ptr_q];
    owner_ack  = owner ? dmem.ack : imem.ack;
    ack_int    = g_resetn & owner_ack & ~fifo_empty;
    pop        = mem.recv & ack_int;
  end

  // State register: lock, ownership FIFO and round-robin history
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lock_valid_q <= 1'b0;
      lock_sel_q   <= SEL_IMEM;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 3'd0;
      for (int i = 0; i < OUTSTANDING; i++) own_q[i] <= SEL_IMEM;
`ifndef IC_ARB_DMEM_PRIO_EN
      rr_last_q    <= SEL_IMEM;
`endif
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_sel_q   <= lock_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (push) own_q[wr_ptr_q] <= sel;
`ifndef IC_ARB_DMEM_PRIO_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  // Next state: a stalled request locks selection until granted or abandoned
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_sel_d   = lock_sel_q;
    if (lock_valid_q && !locked_req) begin
      lock_valid_d = 1'b0;
    end else if (req_any && !mem.gnt) begin
      lock_valid_d = 1'b1;
      lock_sel_d   = sel;
    end else if (push) begin
      lock_valid_d = 1'b0;
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + {2'b00, push} - {2'b00, pop};
`ifndef IC_ARB_DMEM_PRIO_EN
    rr_last_d = push ? sel : rr_last_q;
`endif
  end

  // Outputs: request mux toward target, grant and response routing back to owners
  always_comb begin
    mem.req   = req_any;
    mem.wen   = g_resetn & (sel ? dmem.wen : imem.wen);
    mem.strb  = g_resetn ? (sel ? dmem.strb  : imem.strb)  : 4'h0;
    mem.wdata = g_resetn ? (sel ? dmem.wdata : imem.wdata) : 32'h0;
    mem.addr  = g_resetn ? (sel ? dmem.addr  : imem.addr)  : 32'h0;
    mem.ack   = ack_int;

    imem.gnt  = mem.gnt & req_any & (sel == SEL_IMEM);
    dmem.gnt  = mem.gnt & req_any & (sel == SEL_DMEM);

    imem.recv  = g_resetn & mem.recv & ~fifo_empty & (owner == SEL_IMEM);
    dmem.recv  = g_resetn & mem.recv & ~fifo_empty & (owner == SEL_DMEM);
    imem.error = imem.recv & mem.error;
    dmem.error = dmem.recv & mem.error;
    imem.rdata = imem.recv ? mem.rdata : 32'h0;
    dmem.rdata = dmem.recv ? mem.rdata : 32'h0;

    arb_pending = count_q;
  end

endmodule

// File: tb/tb_ic_mem_arbiter.sv
// tb/tb_ic_mem_arbiter.sv - directed self-checking bench for ic_mem_arbiter
module tb_ic_mem_arbiter;

  logic       g_clk = 1'b0;
  logic       g_resetn = 1'b0;
  logic [2:0] arb_pending;
  int         n_cmp = 0;
  int         n_bad = 0;

  ic_mem_if imem_bus();
  ic_mem_if dmem_bus();
  ic_mem_if mem_bus();

  ic_mem_arbiter #(.OUTSTANDING(2)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .imem       (imem_bus),
    .dmem       (dmem_bus),
    .mem        (mem_bus),
    .arb_pending(arb_pending)
  );

  // 10 ns clock
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_bus.req = 0; imem_bus.wen = 0; imem_bus.strb = 4'h0; imem_bus.wdata = 0; imem_bus.addr = 0; imem_bus.ack = 0;
    dmem_bus.req = 0; dmem_bus.wen = 0; dmem_bus.strb = 4'h0; dmem_bus.wdata = 0; dmem_bus.addr = 0; dmem_bus.ack = 0;
    mem_bus.gnt = 0; mem_bus.recv = 0; mem_bus.error = 0; mem_bus.rdata = 0;
  endtask

  logic order [4];
  logic last_owner;

  initial begin
`ifdef IC_ARB_DMEM_PRIO_EN
    order[0] = 1; order[1] = 1; order[2] = 1; order[3] = 1;
`else
    order[0] = 1; order[1] = 0; order[2] = 1; order[3] = 0;
`endif
    idle_inputs();
    // Reset: outputs zero even with live inputs
    imem_bus.req = 1; mem_bus.gnt = 1; mem_bus.recv = 1; imem_bus.ack = 1;
    #3;
    chk("rst_mem_req", mem_bus.req, 0);
    chk("rst_imem_gnt", imem_bus.gnt, 0);
    chk("rst_imem_recv", imem_bus.recv, 0);
    chk("rst_pending", arb_pending, 0);
    tick();
    g_resetn = 1;
    idle_inputs();

    // Single imem read
    tick();
    imem_bus.req = 1; imem_bus.addr = 32'h2000_0010; mem_bus.gnt = 1;
    #1;
    chk("t1_imem_gnt", imem_bus.gnt, 1);
    chk("t1_dmem_gnt", dmem_bus.gnt, 0);
    chk("t1_mem_addr", mem_bus.addr, 32'h2000_0010);
    tick();
    idle_inputs();
    mem_bus.recv = 1; mem_bus.rdata = 32'hDEAD_BEEF; mem_bus.error = 1; imem_bus.ack = 1;
    #1;
    chk("t1_pending1", arb_pending, 1);
    chk("t1_imem_recv", imem_bus.recv, 1);
    chk("t1_imem_rdata", imem_bus.rdata, 32'hDEAD_BEEF);
    chk("t1_imem_error", imem_bus.error, 1);
    chk("t1_dmem_recv", dmem_bus.recv, 0);
    chk("t1_dmem_rdata", dmem_bus.rdata, 0);
    chk("t1_mem_ack", mem_bus.ack, 1);
    tick();
    idle_inputs();
    #1;
    chk("t1_pending0", arb_pending, 0);

    // Both requesting, continuous grant with response+ack every cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      imem_bus.req = 1; dmem_bus.req = 1; mem_bus.gnt = 1;
      mem_bus.recv = 1; imem_bus.ack = 1; dmem_bus.ack = 1;
      #1;
      chk($sformatf("t2_dmem_gnt%0d", i), dmem_bus.gnt, order[i]);
      chk($sformatf("t2_imem_gnt%0d", i), imem_bus.gnt, !order[i]);
      if (i > 0) chk($sformatf("t2_dmem_recv%0d", i), dmem_bus.recv, order[i-1]);
      else       chk("t2_recv_empty", dmem_bus.recv | imem_bus.recv, 0);
    end
    last_owner = order[3];
    tick();
    idle_inputs();
    mem_bus.recv = 1; imem_bus.ack = 1; dmem_bus.ack = 1;
    #1;
    chk("t2_pending", arb_pending, 1);
    chk("t2_drain_imem", imem_bus.recv, !last_owner);
    chk("t2_drain_dmem", dmem_bus.recv, last_owner);
    tick();
    idle_inputs();

    // dmem grant so round-robin would favour imem next
    dmem_bus.req = 1; dmem_bus.addr = 32'h3000_0000; mem_bus.gnt = 1;
    #1;
    chk("t3a_dmem_gnt", dmem_bus.gnt, 1);
    tick();
    idle_inputs();
    mem_bus.recv = 1; dmem_bus.ack = 1;
    #1;
    chk("t3a_dmem_recv", dmem_bus.recv, 1);
    tick();
    idle_inputs();

    // Stalled dmem holds the port when imem arrives
    for (int i = 0; i < 3; i++) begin
      dmem_bus.req = 1; dmem_bus.addr = 32'h3000_0000;
      #1;
      chk($sformatf("t3_stall_addr%0d", i), mem_bus.addr, 32'h3000_0000);
      chk($sformatf("t3_stall_gnt%0d", i), dmem_bus.gnt, 0);
      tick();
    end
    imem_bus.req = 1; imem_bus.addr = 32'h2000_0100;
    #1;
    chk("t3_locked_addr", mem_bus.addr, 32'h3000_0000);
    chk("t3_locked_imem_gnt", imem_bus.gnt, 0);
    tick();
    mem_bus.gnt = 1;
    #1;
    chk("t3_dmem_gnt", dmem_bus.gnt, 1);
    chk("t3_imem_gnt", imem_bus.gnt, 0);
    tick();
    idle_inputs();
    mem_bus.recv = 1; dmem_bus.ack = 1;
    #1;
    chk("t3_dmem_recv", dmem_bus.recv, 1);
    chk("t3_imem_recv", imem_bus.recv, 0);
    tick();
    idle_inputs();
    #1;
    chk("t3_pending0", arb_pending, 0);

    // Fill the ownership FIFO, then check full blocking and in-order pop
    imem_bus.req = 1; imem_bus.addr = 32'h2000_0200; mem_bus.gnt = 1;
    #1;
    chk("t4_imem_gnt", imem_bus.gnt, 1);
    tick();
    imem_bus.req = 0; dmem_bus.req = 1; dmem_bus.addr = 32'h3000_0040;
    #1;
    chk("t4_dmem_gnt", dmem_bus.gnt, 1);
    chk("t4_pending1", arb_pending, 1);
    tick();
    dmem_bus.req = 0; imem_bus.req = 1;
    #1;
    chk("t4_full_pending", arb_pending, 2);
    chk("t4_full_mem_req", mem_bus.req, 0);
    chk("t4_full_imem_gnt", imem_bus.gnt, 0);
    tick();
    mem_bus.recv = 1; imem_bus.ack = 1; mem_bus.rdata = 32'h1111_2222;
    #1;
    chk("t4_pop_imem_recv", imem_bus.recv, 1);
    chk("t4_pop_imem_rdata", imem_bus.rdata, 32'h1111_2222);
    chk("t4_pop_dmem_recv", dmem_bus.recv, 0);
    chk("t4_pop_mem_ack", mem_bus.ack, 1);
    chk("t4_pop_mem_req", mem_bus.req, 0);
    tick();
    mem_bus.recv = 0; imem_bus.ack = 0;
    #1;
    chk("t4_after_pending", arb_pending, 1);
    chk("t4_after_mem_req", mem_bus.req, 1);
    chk("t4_after_imem_gnt", imem_bus.gnt, 1);
    tick();
    #1;
    chk("t4_refill_pending", arb_pending, 2);

    // Asynchronous reset with two outstanding
    g_resetn = 0;
    mem_bus.recv = 1; imem_bus.ack = 1; dmem_bus.ack = 1;
    #1;
    chk("t6_rst_pending", arb_pending, 0);
    chk("t6_rst_mem_req", mem_bus.req, 0);
    chk("t6_rst_imem_gnt", imem_bus.gnt, 0);
    chk("t6_rst_dmem_recv", dmem_bus.recv, 0);
    chk("t6_rst_mem_ack", mem_bus.ack, 0);
    chk("t6_rst_mem_addr", mem_bus.addr, 0);
    tick();
    g_resetn = 1;
    idle_inputs();

    // Stray response with nothing outstanding
    mem_bus.recv = 1; mem_bus.error = 1; mem_bus.rdata = 32'hCAFE_F00D;
    imem_bus.ack = 1; dmem_bus.ack = 1;
    #1;
    chk("t5_imem_recv", imem_bus.recv, 0);
    chk("t5_dmem_recv", dmem_bus.recv, 0);
    chk("t5_imem_error", imem_bus.error, 0);
    chk("t5_dmem_error", dmem_bus.error, 0);
    chk("t5_imem_rdata", imem_bus.rdata, 0);
    chk("t5_mem_ack", mem_bus.ack, 0);
    tick();
    idle_inputs();
    #1;
    chk("t5_pending", arb_pending, 0);

    // First tie after reset goes to dmem
    imem_bus.req = 1; dmem_bus.req = 1; mem_bus.gnt = 1;
    #1;
    chk("t7_tie_dmem_gnt", dmem_bus.gnt, 1);
    chk("t7_tie_imem_gnt", imem_bus.gnt, 0);
    tick();
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
